div: RTL and testbench

Multi-cycle 32-bit signed/unsigned integer divider that sequences the HI/LO result path for DIV and DIVU. The execute stage launches it, holds the pipeline stalled while it runs, and forwards the 64-bit result to the HI/LO write-back path (whilo/hi/lo) through the memory stage. The quotient goes to LO and the remainder goes to HI. The divider is a radix-2 restoring divider driven by a small state machine: one quotient bit per cycle.

---
 rtl/div_pkg.sv | 52 +++++
 rtl/div_if.sv | 24 ++
 rtl/div.sv | 133 +++++++++++++
 tb/tb_div.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO radix-2 restoring divider: widths, state
// encoding, handshake levels and the operand-preparation helpers.
package div_pkg;

    localparam int REG_BUS = 32;
    localparam int CNT_W   = 6;

    localparam logic [CNT_W-1:0] DIV_ITERS = 6'd32;
    localparam logic [CNT_W-1:0] CNT_ONE   = 6'd1;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Everything latched at launch: unsigned magnitudes plus the two sign fixes
    // still owed at the end of the iterations.
    typedef struct packed {
        logic [REG_BUS-1:0] mag_dividend;
        logic [REG_BUS-1:0] mag_divisor;
        logic               neg_quo;
        logic               neg_rem;
    } div_setup_t;

    function automatic logic [REG_BUS-1:0] cond_negate(
        input logic [REG_BUS-1:0] v,
        input logic               neg
    );
        return neg ? -v : v;
    endfunction

    function automatic div_setup_t prepare(
        input logic               is_signed,
        input logic [REG_BUS-1:0] dividend,
        input logic [REG_BUS-1:0] divisor
    );
        div_setup_t s;
        s.mag_dividend = cond_negate(dividend, is_signed & dividend[REG_BUS-1]);
        s.mag_divisor  = cond_negate(divisor,  is_signed & divisor[REG_BUS-1]);
        s.neg_quo      = is_signed & (dividend[REG_BUS-1] ^ divisor[REG_BUS-1]);
        s.neg_rem      = is_signed & dividend[REG_BUS-1];
        return s;
    endfunction

endpackage

// File: rtl/div_if.sv
// Launch/result handshake between the execute stage (master) and the divider
// (slave). Names keep the pipeline's _i/_o view from the divider side.
interface div_if;
    import div_pkg::*;

    logic                   signed_div_i;
    logic [REG_BUS-1:0]     opdata1_i;
    logic [REG_BUS-1:0]     opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*REG_BUS-1:0]   result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit DIV/DIVU: one quotient bit per cycle, result {rem, quo}
// held on result_o while start_i stays high after ready_o.
module div
    import div_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    div_state_e             r_state;
    div_state_e             w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [REG_BUS-1:0]     r_quo;
    logic [REG_BUS-1:0]     r_rem;
    logic [REG_BUS-1:0]     r_divisor;
    logic                   r_neg_quo;
    logic                   r_neg_rem;
    logic [2*REG_BUS-1:0]   r_result;
    logic                   r_ready;

    logic [REG_BUS:0]       w_partial;
    logic [REG_BUS-1:0]     w_diff;
    logic                   w_fits;
    logic                   w_launch;
    logic                   w_cancel;
    div_setup_t             w_setup;

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

    assign w_launch = (bus.start_i == DIV_START) && !bus.annul_i;
    assign w_cancel = (bus.start_i == DIV_STOP) || bus.annul_i;
    assign w_setup  = prepare(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);

    // r_quo starts as the dividend magnitude and is shifted left each step, so
    // its MSB feeds the partial remainder while quotient bits enter at the LSB.
    // The compare is 33 bits wide; when it succeeds the true difference is below
    // the divisor, so the low 32 bits of the subtraction are exact.
    // NOTE: every always_comb output gets a value on all paths so no latch is inferred.
    always_comb begin
        w_partial = {r_rem, r_quo[REG_BUS-1]};
        w_fits    = (w_partial >= {1'b0, r_divisor});
        w_diff    = w_partial[REG_BUS-1:0] - r_divisor;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            DIV_FREE: begin
                if (w_launch) begin
                    w_next_state = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: w_next_state = DIV_END;
            DIV_ON: begin
                if (w_cancel) begin
                    w_next_state = DIV_FREE;
                end else if (r_cnt == DIV_ITERS) begin
                    w_next_state = DIV_END;
                end
            end
            DIV_END: begin
                if (w_cancel) begin
                    w_next_state = DIV_FREE;
                end
            end
            default: w_next_state = DIV_FREE;
        endcase
    end

    // NOTE: state and datapath use non-blocking assignments; the synchronous
    // reset clears every register, including the datapath, so no stale operand
    // can leak into a result after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                DIV_FREE: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                    if (w_next_state == DIV_ON) begin
                        r_quo     <= w_setup.mag_dividend;
                        r_divisor <= w_setup.mag_divisor;
                        r_neg_quo <= w_setup.neg_quo;
                        r_neg_rem <= w_setup.neg_rem;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (w_next_state == DIV_FREE) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end else if (r_cnt != DIV_ITERS) begin
                        r_rem <= w_fits ? w_diff : w_partial[REG_BUS-1:0];
                        r_quo <= {r_quo[REG_BUS-2:0], w_fits};
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_result <= {cond_negate(r_rem, r_neg_rem),
                                     cond_negate(r_quo, r_neg_quo)};
                        r_ready  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (w_next_state == DIV_FREE) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected {rem, quo} and ready cycle,
// a monitor pops on each ready_o rise and compares.
module tb_div;
    import div_pkg::*;

    typedef struct {
        logic [63:0] result;
        int          ready_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    div_if u_if ();

    div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per ready_o rising edge.
    initial begin
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.ready_o === 1'b1 && prev_ready !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", {63'd0, u_if.ready_o}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, u_if.result_o, e.result);
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.ready_cyc));
                end
            end
            prev_ready = u_if.ready_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        u_if.start_i      = 1'b0;
        u_if.annul_i      = 1'b0;
        u_if.signed_div_i = 1'b0;
        u_if.opdata1_i    = '0;
        u_if.opdata2_i    = '0;
    endtask

    task automatic launch(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input bit scored);
        exp_t e;
        u_if.signed_div_i = sgn;
        u_if.opdata1_i    = a;
        u_if.opdata2_i    = b;
        u_if.start_i      = 1'b1;
        u_if.annul_i      = 1'b0;
        if (scored) begin
            e.result    = exp;
            e.ready_cyc = cyc + lat;
            e.name      = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_ready(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Operand changes after launch must be ignored.
                u_if.opdata1_i    = $urandom;
                u_if.opdata2_i    = $urandom;
                u_if.signed_div_i = ~u_if.signed_div_i;
            end
            if (u_if.ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, {63'd0, u_if.ready_o}, 64'd1);
            sb_q.delete();
        end
    endtask

    task automatic finish_op(input string name);
        u_if.start_i = 1'b0;
        @(negedge clk);
        check({name, "_drop_ready"}, {63'd0, u_if.ready_o}, 64'd0);
        check({name, "_drop_result"}, u_if.result_o, 64'd0);
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        launch(name, sgn, a, b, exp, lat, 1'b1);
        wait_ready(name);
        finish_op(name);
    endtask

    task automatic check_free(input string name);
        check({name, "_state"}, 64'(u_dut.r_state), 64'(DIV_FREE));
        check({name, "_ready"}, {63'd0, u_if.ready_o}, 64'd0);
        check({name, "_result"}, u_if.result_o, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        check_free("reset");
        check("reset_cnt", 64'(u_dut.r_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 100 / 7 with a held result, then release.
        launch("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b1);
        wait_ready("divu_100_7");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", u_if.result_o, {32'd2, 32'd14});
            check("hold_ready", {63'd0, u_if.ready_o}, 64'd1);
        end
        finish_op("divu_100_7");

        run_op("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        run_op("div_7_m2",  1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 34);
        run_op("divu_min_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 34);
        run_op("div_m12345_67", 1'b1, 32'hFFFF_CFC7, 32'd67, {32'hFFFF_FFEF, 32'hFFFF_FF48}, 34);

        // Divide by zero, then a normal op after one DivFree cycle.
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

        // Annul in cycle 10; restart accepted one cycle later.
        launch("annul_victim", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'd0, 34, 1'b0);
        repeat (10) @(negedge clk);
        u_if.annul_i = 1'b1;
        @(negedge clk);
        u_if.annul_i = 1'b0;
        check_free("annul");
        run_op("after_annul", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34);

        // Annul together with start in DivFree: nothing launches.
        u_if.opdata1_i = 32'd50;
        u_if.opdata2_i = 32'd5;
        u_if.start_i   = 1'b1;
        u_if.annul_i   = 1'b1;
        @(negedge clk);
        check_free("annul_start");
        run_op("after_annul_start", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);

        // Reset asserted in cycle 20 of an operation.
        launch("rst_victim", 1'b0, 32'd12345, 32'd67, 64'd0, 34, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_free("mid_reset");
        check("mid_reset_cnt", 64'(u_dut.r_cnt), 64'd0);
        rst = 1'b0;
        u_if.start_i = 1'b0;
        @(negedge clk);

        // start_i dropped in cycle 15 aborts the same way.
        launch("abort_victim", 1'b0, 32'd12345, 32'd67, 64'd0, 34, 1'b0);
        repeat (15) @(negedge clk);
        u_if.start_i = 1'b0;
        @(negedge clk);
        check_free("abort");
        run_op("divu_12345_67", 1'b0, 32'd12345, 32'd67, {32'd17, 32'd184}, 34);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
